dispatch_fence_scheduler: RTL and testbench
===========================================

// Module: dispatch_fence_scheduler
// PURPOSE
//  Shares the single operand-collector dispatch port between the per-warp wait buffers using
//  round-robin. Also enforces per-warp memory fences. A dispatched fence blocks later memory ops
//  and fences of its warp until every memory op dispatched earlier by that warp has retired.
//  Sits between the per-warp wait buffers and the operand collector; the memory unit feeds it.
// PARAMETERS
//  NumWarps          8   number of warps / wait buffers arbitrated
//  MaxOutstandingMem 15  max in-flight memory ops per warp (counter saturation limit)
//  WidWidth          $clog2(NumWarps) (dependent, min 1), warp id width
//  CntWidth          $clog2(MaxOutstandingMem+1) (dependent), per-warp counter width
// PORTS
//  clk_i             in  1         clock
//  rst_i             in  1         synchronous reset, active-high
//  wb_valid_i        in  NumWarps  warp w has a dispatch-ready instruction
//  wb_is_mem_i       in  NumWarps  that instruction is a memory op
//  wb_is_fence_i     in  NumWarps  that instruction is a fence (never also mem)
//  wb_ready_o        out NumWarps  one-hot: warp w's instruction is dispatched this cycle
//  disp_valid_o      out 1         an eligible instruction is offered to the operand collector
//  disp_warp_o       out WidWidth  warp id of the offered instruction
//  opc_ready_i       in  1         operand collector accepts
//  mem_done_valid_i  in  1         a memory op retired
//  mem_done_warp_i   in  WidWidth  warp of the retired memory op
//  fence_active_o    out NumWarps  fence pending per warp (fence_q)
//  idle_o            out 1         all counters zero and no fence pending
// BEHAVIOUR
//  - Dispatch handshake: hs = disp_valid_o && opc_ready_i.
//    wb_ready_o[sel] = hs; all other bits are 0.
//  - State per warp: cnt_q[w] (CntWidth), fence_q[w].
//    Global state: rr_q (WidWidth), the round-robin pointer.
//  - Reset (rst_i high at posedge): cnt_q=0, fence_q=0, rr_q=0.
//    While rst_i is high, disp_valid_o=0, wb_ready_o=0, disp_warp_o=0.
//    After reset: fence_active_o=0, idle_o=1.
//  - Eligibility: elig[w] = wb_valid_i[w]
//      && !(wb_is_mem_i[w] && (fence_q[w] || cnt_q[w]==MaxOutstandingMem))
//      && !(wb_is_fence_i[w] && fence_q[w]).
//    Non-memory, non-fence ops are never blocked.
//  - Arbitration is combinational, 0-cycle latency.
//    sel is the first eligible warp scanning rr_q, rr_q+1, ... with wrap-around mod NumWarps.
//    disp_valid_o = |elig; disp_warp_o = sel, or 0 when nothing is eligible.
//    No lock-in: sel may change while opc_ready_i=0.
//  - On hs: rr_q <= (sel==NumWarps-1) ? 0 : sel+1. Without hs, rr_q holds.
//  - Counter: inc = hs && sel==w && wb_is_mem_i[w];
//    dec = mem_done_valid_i && mem_done_warp_i==w.
//    inc&&dec -> unchanged; inc -> +1; dec -> -1. cnt_d is the resulting value.
//    dec when cnt_q==0 is ignored (cnt stays 0; simulation assertion fires).
//    inc never occurs at Max, because eligibility prevents it.
//  - Fence: on hs of a fence for warp w, fence_q[w] <= (cnt_d[w]!=0).
//    If all earlier memory ops have already drained (incl. a same-cycle retire), no fence is held.
//    While fence_q[w]=1 it clears on the posedge where cnt_d[w]==0.
//    Blocked memory ops become eligible the following cycle.
//  - fence_active_o = fence_q; idle_o = (all cnt_q==0) && !(|fence_q). Both are registered-state only.
//  - Assertions (non-synthesis): wb_ready_o is one-hot0; wb_is_mem_i && wb_is_fence_i never both set;
//    no dec on a zero counter; hs implies elig[sel].
// TESTING
//  1 Reset: assert rst_i with wb_valid_i=8'hFF -> disp_valid_o=0, wb_ready_o=0.
//    One cycle after release: disp_warp_o=0, idle_o=1.
//  2 Round-robin: wb_valid_i=8'b1010_0101, opc_ready_i=1 for 5 cycles
//    -> dispatched warps 0,2,5,7,0; rr_q ends at 1.
//  3 Backpressure: warps 3 and 6 valid, opc_ready_i=0 for 3 cycles -> disp_warp_o=3, wb_ready_o=0, rr_q unchanged.
//    Then opc_ready_i=1 -> wb_ready_o=8'b0000_1000.
//  4 Fence: warp 1 dispatches 2 mem ops (cnt=2), then a fence -> fence_active_o[1]=1.
//    A mem op from warp 1 is not dispatched while an ALU op from warp 1 is.
//    Retire both mem ops -> fence clears the same edge cnt hits 0; the mem op dispatches next cycle.
//  5 Fence on drain: cnt[4]=1, and the fence dispatch coincides with mem_done for warp 4
//    -> fence_active_o[4] stays 0, cnt[4]=0.
//  6 Saturation/simultaneous: cnt[2]=15 -> warp 2 mem op ineligible.
//    Mem dispatch and retire of warp 2 in the same cycle at cnt=7 -> cnt stays 7.

Source files
------------

// File: rtl/dispatch_fence_scheduler.sv
// dispatch_fence_scheduler
//   Round-robin arbiter that shares the single operand-collector dispatch port between the
//   per-warp wait buffers. It also tracks per-warp memory fences. A dispatched fence holds off
//   later memory ops and fences of its warp until every memory op dispatched earlier by that
//   warp has retired.
// Ports
//   clk_i, rst_i       clock, synchronous active-high reset
//   wb_valid_i         per-warp dispatch-ready instruction
//   wb_is_mem_i        per-warp instruction is a memory op
//   wb_is_fence_i      per-warp instruction is a fence
//   wb_ready_o         one-hot grant, asserted on the dispatch handshake
//   disp_valid_o       an eligible instruction is offered
//   disp_warp_o        warp id of the offered instruction
//   opc_ready_i        operand collector accepts
//   mem_done_valid_i   a memory op retired
//   mem_done_warp_i    warp of the retired memory op
//   fence_active_o     per-warp fence pending
//   idle_o             no outstanding memory ops and no fence pending
module dispatch_fence_scheduler #(
  parameter int unsigned NumWarps          = 8,
  parameter int unsigned MaxOutstandingMem = 15,
  localparam int unsigned WidWidth = (NumWarps > 1) ? $clog2(NumWarps) : 1,
  localparam int unsigned CntWidth = $clog2(MaxOutstandingMem + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NumWarps-1:0] wb_valid_i,
  input  logic [NumWarps-1:0] wb_is_mem_i,
  input  logic [NumWarps-1:0] wb_is_fence_i,
  output logic [NumWarps-1:0] wb_ready_o,
  output logic                disp_valid_o,
  output logic [WidWidth-1:0] disp_warp_o,
  input  logic                opc_ready_i,
  input  logic                mem_done_valid_i,
  input  logic [WidWidth-1:0] mem_done_warp_i,
  output logic [NumWarps-1:0] fence_active_o,
  output logic                idle_o
);

  logic [CntWidth-1:0] cnt_q [NumWarps];
  logic [CntWidth-1:0] cnt_d [NumWarps];
  logic [NumWarps-1:0] fence_q, fence_d;
  logic [WidWidth-1:0] rr_q, rr_d;

  logic [NumWarps-1:0] elig;
  logic [NumWarps-1:0] inc, dec;
  logic [WidWidth-1:0] sel;
  logic                any_elig;
  logic                hs;
  logic                cnt_all_zero;

  always_comb begin
    elig = '0;
    for (int w = 0; w < NumWarps; w++) begin
      elig[w] = wb_valid_i[w]
          && !(wb_is_mem_i[w] && (fence_q[w] || cnt_q[w] == CntWidth'(MaxOutstandingMem)))
          && !(wb_is_fence_i[w] && fence_q[w]);
    end
  end

  // First eligible warp scanning from rr_q with wrap-around.
  always_comb begin
    int unsigned idx;
    logic [WidWidth-1:0] idx_w;
    idx      = 0;
    idx_w    = '0;
    sel      = '0;
    any_elig = 1'b0;
    for (int unsigned k = 0; k < NumWarps; k++) begin
      idx   = (32'(rr_q) + k) % NumWarps;
      idx_w = WidWidth'(idx);
      if (!any_elig && elig[idx_w]) begin
        any_elig = 1'b1;
        sel      = idx_w;
      end
    end
  end

  assign disp_valid_o = any_elig && !rst_i;
  assign disp_warp_o  = disp_valid_o ? sel : '0;
  assign hs           = disp_valid_o && opc_ready_i;

  always_comb begin
    wb_ready_o = '0;
    inc        = '0;
    dec        = '0;
    fence_d    = fence_q;
    for (int w = 0; w < NumWarps; w++) begin
      wb_ready_o[w] = hs && (sel == WidWidth'(w));
      inc[w]        = wb_ready_o[w] && wb_is_mem_i[w];
      dec[w]        = mem_done_valid_i && (mem_done_warp_i == WidWidth'(w));
      cnt_d[w]      = cnt_q[w];
      if (inc[w] && !dec[w]) begin
        cnt_d[w] = cnt_q[w] + 1'b1;
      end else if (dec[w] && !inc[w] && cnt_q[w] != '0) begin
        cnt_d[w] = cnt_q[w] - 1'b1;
      end
      // A fence only latches if memory ops are still in flight after this edge.
      if (wb_ready_o[w] && wb_is_fence_i[w]) begin
        fence_d[w] = (cnt_d[w] != '0);
      end else if (fence_q[w] && cnt_d[w] == '0) begin
        fence_d[w] = 1'b0;
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (hs) begin
      rr_d = (sel == WidWidth'(NumWarps - 1)) ? '0 : sel + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int w = 0; w < NumWarps; w++) begin
        cnt_q[w] <= '0;
      end
      fence_q <= '0;
      rr_q    <= '0;
    end else begin
      for (int w = 0; w < NumWarps; w++) begin
        cnt_q[w] <= cnt_d[w];
      end
      fence_q <= fence_d;
      rr_q    <= rr_d;
    end
  end

  always_comb begin
    cnt_all_zero = 1'b1;
    for (int w = 0; w < NumWarps; w++) begin
      if (cnt_q[w] != '0) begin
        cnt_all_zero = 1'b0;
      end
    end
  end

  assign fence_active_o = fence_q;
  assign idle_o         = cnt_all_zero && !(|fence_q);

  a_ready_onehot0: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(wb_ready_o));
  a_mem_not_fence: assert property (@(posedge clk_i) disable iff (rst_i)
      (wb_valid_i & wb_is_mem_i & wb_is_fence_i) == '0);
  a_no_dec_zero: assert property (@(posedge clk_i) disable iff (rst_i)
      !(mem_done_valid_i && cnt_q[mem_done_warp_i] == '0));
  a_hs_elig: assert property (@(posedge clk_i) disable iff (rst_i) !hs || elig[sel]);

endmodule

// File: tb/tb_dispatch_fence_scheduler.sv
module tb_dispatch_fence_scheduler;

  logic       clk;
  logic       rst;
  logic [7:0] wb_valid, wb_is_mem, wb_is_fence, wb_ready;
  logic       disp_valid;
  logic [2:0] disp_warp;
  logic       opc_ready;
  logic       done_valid;
  logic [2:0] done_warp;
  logic [7:0] fence_active;
  logic       idle;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic       rst;
    logic [7:0] valid;
    logic [7:0] mem;
    logic [7:0] fen;
    logic       rdy;
    logic       dv;
    logic [2:0] dw;
    logic       e_dv;
    logic [2:0] e_w;
    logic [7:0] e_rdy;
    logic       chk_st;
    logic [7:0] e_fence;
    logic       e_idle;
  } vec_t;

  vec_t vecs[$];

  dispatch_fence_scheduler dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .wb_valid_i       (wb_valid),
    .wb_is_mem_i      (wb_is_mem),
    .wb_is_fence_i    (wb_is_fence),
    .wb_ready_o       (wb_ready),
    .disp_valid_o     (disp_valid),
    .disp_warp_o      (disp_warp),
    .opc_ready_i      (opc_ready),
    .mem_done_valid_i (done_valid),
    .mem_done_warp_i  (done_warp),
    .fence_active_o   (fence_active),
    .idle_o           (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic [7:0] v, logic [7:0] m, logic [7:0] f, logic o,
                              logic dv, logic [2:0] dw, logic e_dv, logic [2:0] e_w,
                              logic [7:0] e_rdy, logic chk_st, logic [7:0] e_fence,
                              logic e_idle);
    vec_t x;
    x.rst = r; x.valid = v; x.mem = m; x.fen = f; x.rdy = o; x.dv = dv; x.dw = dw;
    x.e_dv = e_dv; x.e_w = e_w; x.e_rdy = e_rdy;
    x.chk_st = chk_st; x.e_fence = e_fence; x.e_idle = e_idle;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end else begin
      passed++;
    end
  endtask

  // Drive on the falling edge, sample 1 time unit later; the next rising edge commits.
  task automatic run_vec(input string tag, input vec_t v);
    @(negedge clk);
    rst = v.rst; wb_valid = v.valid; wb_is_mem = v.mem; wb_is_fence = v.fen;
    opc_ready = v.rdy; done_valid = v.dv; done_warp = v.dw;
    #1;
    chk({tag, "_disp_valid"}, 32'(disp_valid), 32'(v.e_dv));
    chk({tag, "_disp_warp"}, 32'(disp_warp), 32'(v.e_w));
    chk({tag, "_wb_ready"}, 32'(wb_ready), 32'(v.e_rdy));
    if (v.chk_st) begin
      chk({tag, "_fence_active"}, 32'(fence_active), 32'(v.e_fence));
      chk({tag, "_idle"}, 32'(idle), 32'(v.e_idle));
    end
  endtask

  initial begin
    rst = 1'b1; wb_valid = 8'hFF; wb_is_mem = '0; wb_is_fence = '0;
    opc_ready = 1'b1; done_valid = 1'b0; done_warp = '0;

    //                rst valid  mem    fence  rdy dv dw  e_dv e_w e_rdy  st e_fen  e_idle
    // Reset
    vecs.push_back(mk(1, 8'hFF, 8'h00, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0, 8'h00, 1));
    vecs.push_back(mk(1, 8'hFF, 8'h00, 8'h00, 1, 0, 0, 0, 0, 8'h00, 1, 8'h00, 1));
    vecs.push_back(mk(0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h00, 1, 8'h00, 1));
    // Round-robin over 1010_0101: 0,2,5,7,0 then pointer sits at 1
    vecs.push_back(mk(0, 8'hA5, 8'h00, 8'h00, 1, 0, 0, 1, 0, 8'h01, 1, 8'h00, 1));
    vecs.push_back(mk(0, 8'hA5, 8'h00, 8'h00, 1, 0, 0, 1, 2, 8'h04, 1, 8'h00, 1));
    vecs.push_back(mk(0, 8'hA5, 8'h00, 8'h00, 1, 0, 0, 1, 5, 8'h20, 1, 8'h00, 1));
    vecs.push_back(mk(0, 8'hA5, 8'h00, 8'h00, 1, 0, 0, 1, 7, 8'h80, 1, 8'h00, 1));
    vecs.push_back(mk(0, 8'hA5, 8'h00, 8'h00, 1, 0, 0, 1, 0, 8'h01, 1, 8'h00, 1));
    vecs.push_back(mk(0, 8'hFF, 8'h00, 8'h00, 0, 0, 0, 1, 1, 8'h00, 1, 8'h00, 1));
    // Backpressure on warps 3,6: pointer holds at 1, then grant 3 moves it to 4
    vecs.push_back(mk(0, 8'h48, 8'h00, 8'h00, 0, 0, 0, 1, 3, 8'h00, 1, 8'h00, 1));
    vecs.push_back(mk(0, 8'h48, 8'h00, 8'h00, 0, 0, 0, 1, 3, 8'h00, 1, 8'h00, 1));
    vecs.push_back(mk(0, 8'h48, 8'h00, 8'h00, 0, 0, 0, 1, 3, 8'h00, 1, 8'h00, 1));
    vecs.push_back(mk(0, 8'h48, 8'h00, 8'h00, 1, 0, 0, 1, 3, 8'h08, 1, 8'h00, 1));
    vecs.push_back(mk(0, 8'h48, 8'h00, 8'h00, 0, 0, 0, 1, 6, 8'h00, 1, 8'h00, 1));
    // Fence on warp 1 with two memory ops in flight
    vecs.push_back(mk(0, 8'h02, 8'h02, 8'h00, 1, 0, 0, 1, 1, 8'h02, 1, 8'h00, 1));
    vecs.push_back(mk(0, 8'h02, 8'h02, 8'h00, 1, 0, 0, 1, 1, 8'h02, 1, 8'h00, 0));
    vecs.push_back(mk(0, 8'h02, 8'h00, 8'h02, 1, 0, 0, 1, 1, 8'h02, 1, 8'h00, 0));
    vecs.push_back(mk(0, 8'h02, 8'h02, 8'h00, 1, 0, 0, 0, 0, 8'h00, 1, 8'h02, 0));
    vecs.push_back(mk(0, 8'h02, 8'h00, 8'h02, 1, 0, 0, 0, 0, 8'h00, 1, 8'h02, 0));
    vecs.push_back(mk(0, 8'h02, 8'h00, 8'h00, 1, 0, 0, 1, 1, 8'h02, 1, 8'h02, 0));
    vecs.push_back(mk(0, 8'h02, 8'h02, 8'h00, 1, 1, 1, 0, 0, 8'h00, 1, 8'h02, 0));
    vecs.push_back(mk(0, 8'h02, 8'h02, 8'h00, 1, 1, 1, 0, 0, 8'h00, 1, 8'h02, 0));
    vecs.push_back(mk(0, 8'h02, 8'h02, 8'h00, 1, 0, 0, 1, 1, 8'h02, 1, 8'h00, 1));
    vecs.push_back(mk(0, 8'h00, 8'h00, 8'h00, 0, 1, 1, 0, 0, 8'h00, 1, 8'h00, 0));
    // Fence on warp 4 coincides with its last retire: no fence held
    vecs.push_back(mk(0, 8'h10, 8'h10, 8'h00, 1, 0, 0, 1, 4, 8'h10, 1, 8'h00, 1));
    vecs.push_back(mk(0, 8'h10, 8'h00, 8'h10, 1, 1, 4, 1, 4, 8'h10, 1, 8'h00, 0));
    vecs.push_back(mk(0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h00, 1, 8'h00, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec($sformatf("v%0d", i), vecs[i]);
    end

    // Saturation: fill warp 2 to 15 in-flight memory ops
    for (int i = 0; i < 15; i++) begin
      run_vec($sformatf("sat_fill%0d", i),
              mk(0, 8'h04, 8'h04, 8'h00, 1, 0, 0, 1, 2, 8'h04, 1, 8'h00, (i == 0)));
    end
    run_vec("sat_block", mk(0, 8'h04, 8'h04, 8'h00, 1, 0, 0, 0, 0, 8'h00, 1, 8'h00, 0));
    // Drain to 7
    for (int i = 0; i < 8; i++) begin
      run_vec($sformatf("sat_drain%0d", i),
              mk(0, 8'h00, 8'h00, 8'h00, 0, 1, 2, 0, 0, 8'h00, 1, 8'h00, 0));
    end
    // Dispatch and retire together: count must stay 7
    run_vec("simul", mk(0, 8'h04, 8'h04, 8'h00, 1, 1, 2, 1, 2, 8'h04, 1, 8'h00, 0));
    // Exactly 8 more fit before saturation again
    for (int i = 0; i < 8; i++) begin
      run_vec($sformatf("refill%0d", i),
              mk(0, 8'h04, 8'h04, 8'h00, 1, 0, 0, 1, 2, 8'h04, 1, 8'h00, 0));
    end
    run_vec("refill_block", mk(0, 8'h04, 8'h04, 8'h00, 1, 0, 0, 0, 0, 8'h00, 1, 8'h00, 0));
    for (int i = 0; i < 15; i++) begin
      run_vec($sformatf("final_drain%0d", i),
              mk(0, 8'h00, 8'h00, 8'h00, 0, 1, 2, 0, 0, 8'h00, 1, 8'h00, 0));
    end
    run_vec("final_idle", mk(0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h00, 1, 8'h00, 1));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
